uart_tx_serializer: RTL



---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_serializer_if.sv | 20 ++
 rtl/uart_tx_serializer_baud_tick.sv | 26 ++
 rtl/uart_tx_serializer.sv | 131 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the TX serializer and RX path: state encoding,
// default line configuration and bit-period derivation.
package uart_pkg;

  localparam int unsigned DEFAULT_CLK_FREQ = 200_000_000;
  localparam int unsigned DEFAULT_BAUD     = 115_200;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Parallel byte handshake between the bridge TxD datapath and the UART serializer.
interface uart_tx_serializer_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_start;
  logic                 tx_ready;
  logic                 tx_busy;
  logic                 tx_done;

  modport master (
    output tx_data, tx_start,
    input  tx_ready, tx_busy, tx_done
  );

  modport slave (
    input  tx_data, tx_start,
    output tx_ready, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_tx_serializer_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, ticks on the last count.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 1736,
  localparam int unsigned CW = $clog2(CLKS_PER_BIT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          enable,
  output logic          tick,
  output logic [CW-1:0] count
);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  assign tick = enable && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + CW'(1);
    end
  end
endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter with synchronized CTS flow control.
// Define UART_TX_PARITY_EN to append an even parity bit after the data bits.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = DEFAULT_CLK_FREQ,
  parameter int unsigned BAUD         = DEFAULT_BAUD,
  parameter int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD),
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  uart_tx_serializer_if.slave  tx_if,
  input  logic                 cts_n,
  output logic                 TX
);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS);

  uart_state_e          state;
  logic [DATA_BITS-1:0] shift;
  logic [BW-1:0]        bit_idx;
  logic                 tx_line;
  logic                 done_q;
  logic [1:0]           cts_sync;
  logic                 cts_ok;
  logic                 accept;
  logic                 tick;
  logic [CW-1:0]        count;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cts_sync <= '1;
    end else begin
      cts_sync <= {cts_sync[0], cts_n};
    end
  end

  assign cts_ok         = !cts_sync[1];
  assign tx_if.tx_ready = (state == IDLE) && cts_ok;
  assign tx_if.tx_busy  = (state != IDLE);
  assign tx_if.tx_done  = done_q;
  assign accept         = tx_if.tx_start && tx_if.tx_ready;
  assign TX             = tx_line;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .clear  (accept),
    .enable (state != IDLE),
    .tick   (tick),
    .count  (count)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= IDLE;
      shift   <= '0;
      bit_idx <= '0;
      tx_line <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      // Registered one cycle early so the pulse coincides with the last stop-bit cycle.
      done_q <= (state == STOP) && (count == CW'(CLKS_PER_BIT - 2));
      unique case (state)
        IDLE: begin
          tx_line <= 1'b1;
          if (accept) begin
            state   <= START;
            shift   <= tx_if.tx_data;
            bit_idx <= '0;
            tx_line <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^tx_if.tx_data;
`endif
          end
        end
        START: begin
          if (tick) begin
            state   <= DATA;
            tx_line <= shift[0];
          end
        end
        DATA: begin
          if (tick) begin
            shift <= shift >> 1;
            if (bit_idx == BW'(DATA_BITS - 1)) begin
              bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
              tx_line <= parity_q;
`else
              state   <= STOP;
              tx_line <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + BW'(1);
              tx_line <= shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            state   <= STOP;
            tx_line <= 1'b1;
          end
        end
`endif
        STOP: begin
          tx_line <= 1'b1;
          if (tick) begin
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          tx_line <= 1'b1;
        end
      endcase
    end
  end
endmodule
